alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Initiator side of the 16-bit ALU interface: accepts one instruction (op, Rdest, Rsrc) via valid/ready,
//  reads operands from the register file, drives the ALU's A/B/Opcode, captures C/D/Low/Negative/Zero,
//  writes results back and holds the processor flags. It sits between decode and the register file/ALU.
// PARAMETERS
//  DATA_W  16  operand/result width; must match the ALU
//  REG_AW  4   register address width (16 registers)
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high
//  req_valid     in   1       instruction request valid
//  req_ready     out  1       high only in IDLE
//  req_op        in   4       ALU opcode (shared opcode include: ADD SUB CMP CMPR AND OR XOR NOT LSH RSH ARSH MUL FMUL)
//  req_rd        in   REG_AW  Rdest address
//  req_rs        in   REG_AW  Rsrc address
//  rf_raddr_a    out  REG_AW  read port A address (= rd_q)
//  rf_raddr_b    out  REG_AW  read port B address (= rs_q)
//  rf_rdata_a    in   DATA_W  combinational read data for port A
//  rf_rdata_b    in   DATA_W  combinational read data for port B
//  alu_a         out  DATA_W  registered ALU operand A
//  alu_b         out  DATA_W  registered ALU operand B
//  alu_opcode    out  4       registered ALU opcode
//  alu_c         in   DATA_W  ALU result C (MUL: high half)
//  alu_d         in   DATA_W  ALU result D (MUL: low half)
//  alu_low/alu_negative/alu_zero  in  1 each  ALU flags
//  rf_we         out  1       register write enable
//  rf_waddr      out  REG_AW  write address
//  rf_wdata      out  DATA_W  write data
//  flag_low/flag_neg/flag_zero    out 1 each  registered processor flags
//  done          out  1       one-cycle pulse on instruction completion
//  illegal       out  1       qualifies done: opcode not in the supported set
// BEHAVIOUR
//  Reset: state=IDLE; alu_a/alu_b/alu_opcode=0; flags=0; done=illegal=0; rf_we=0; op_q/rd_q/rs_q=0.
//  States: IDLE -> READ -> EXEC -> WB [-> WB2] -> IDLE; CMP/CMPR/illegal go EXEC -> IDLE.
//  IDLE: req_ready=1; on req_valid&req_ready latch op_q, rd_q, rs_q; go to READ. Otherwise hold.
//  READ: capture operands on the edge: alu_opcode<=op_q. For LSH/RSH/ARSH: alu_a<=R[rs] (shift amount),
//    alu_b<=R[rd]. All other ops: alu_a<=R[rd], alu_b<=R[rs]. Go to EXEC.
//  EXEC: ALU is combinational; on the edge capture c_q<=alu_c, d_q<=alu_d. For legal ops, flags<=ALU flags.
//    CMP/CMPR: no writeback; done=1 for this cycle; next IDLE. Illegal op: flags unchanged,
//    no writeback; done=1, illegal=1; next IDLE.
//  WB: rf_we=1, rf_waddr=rd_q, rf_wdata=c_q. Non-MUL: done=1; next IDLE. MUL: next WB2.
//  WB2 (MUL only): rf_we=1, rf_waddr=rd_q+1 mod 2^REG_AW (15 wraps to 0), rf_wdata=d_q; done=1; next IDLE.
//  Latency: accept edge T0; READ cycle T1; EXEC T2; WB T3 (done T3); MUL WB2 T4 (done T4); CMP done T2.
//  Throughput: next accept no earlier than the cycle after done. req_ready is low in all non-IDLE states.
//    Requests held valid wait.
//  rf_we, done and illegal are state decodes ANDed with ~reset: no write or done in any cycle with reset high.
//  Reset in any state: IDLE at the next edge, the in-flight instruction is discarded, flags reset to 0.
//  rd==rs is legal: both operands carry the same register value. The write in WB overwrites that register.
//  alu_a/alu_b/alu_opcode hold their last values in IDLE.
// TESTING
//  R1=5, R2=7, ADD rd=1 rs=2 -> done 3 cycles after accept, write R1=12, flag_zero=0, illegal=0.
//  R3=R4=0x00A0, SUB rd=3 rs=4 -> write R3=0x0000, flag_zero=1; CMP on same -> no rf_we, done at T2, zero=1.
//  R15=0x1234, R6=0x0100, MUL rd=15 rs=6 -> writes R15=0x0012 (T3) then R0=0x3400 (T4), single done at T4.
//  R7=0x0001, R8=4, LSH rd=7 rs=8 -> alu_a=4, alu_b=1, write R7=0x0010.
//  Unused opcode (0xF) with flags preset to 1 -> done with illegal=1, no rf_we, flags unchanged.
//  Reset asserted during WB of an ADD -> rf_we=0 that cycle, req_ready=1 next cycle, flags=0.

Source files
------------

// File: rtl/alu_issue_seq.sv
// alu_issue_seq
//   Issue sequencer for the 16-bit ALU. Takes one instruction (op, Rdest,
//   Rsrc) over a valid/ready handshake, reads both operands from the register
//   file, presents registered A/B/Opcode to the combinational ALU, captures
//   C/D and the flags, and writes the result(s) back. Flags are held here as
//   the processor flag register.
//
//   Ports
//     clk, reset                 clock (rising edge), synchronous active-high reset
//     req_valid/req_ready        instruction handshake (ready only in IDLE)
//     req_op/req_rd/req_rs       opcode, Rdest, Rsrc
//     rf_raddr_a/b, rf_rdata_a/b register file read ports (data combinational)
//     alu_a/alu_b/alu_opcode     registered ALU inputs
//     alu_c/alu_d/alu_low/alu_negative/alu_zero  ALU results and flags
//     rf_we/rf_waddr/rf_wdata    register file write port
//     flag_low/flag_neg/flag_zero processor flags
//     done/illegal               completion pulse, illegal-opcode qualifier
//
//   state | meaning
//   IDLE  | ready for a request, ALU inputs hold last values
//   READ  | operands on the read ports, captured into alu_a/alu_b
//   EXEC  | ALU evaluates, results and flags captured
//   WB    | write C to Rdest
//   WB2   | MUL only: write D to Rdest+1 (wraps)

module alu_issue_seq #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [REG_AW-1:0] req_rs,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [DATA_W-1:0] alu_d,
    input  logic              alu_low,
    input  logic              alu_negative,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_low,
    output logic              flag_neg,
    output logic              flag_zero,
    output logic              done,
    output logic              illegal
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_CMPR = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_LSH  = 4'h8;
    localparam logic [3:0] OP_RSH  = 4'h9;
    localparam logic [3:0] OP_ARSH = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_FMUL = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_WB2
    } state_t;

    state_t            state, state_n;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q, rs_q;
    logic [DATA_W-1:0] c_q, d_q;
    logic              op_legal, op_cmp, op_mul, op_shift;

    assign op_legal = (op_q <= OP_FMUL);
    assign op_cmp   = (op_q == OP_CMP) || (op_q == OP_CMPR);
    assign op_mul   = (op_q == OP_MUL);
    // Shifts take the amount from Rsrc on A and the value from Rdest on B.
    assign op_shift = (op_q == OP_LSH) || (op_q == OP_RSH) || (op_q == OP_ARSH);

    assign rf_raddr_a = rd_q;
    assign rf_raddr_b = rs_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (req_valid) state_n = S_READ;
            S_READ: state_n = S_EXEC;
            S_EXEC: state_n = (!op_legal || op_cmp) ? S_IDLE : S_WB;
            S_WB:   state_n = op_mul ? S_WB2 : S_IDLE;
            S_WB2:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs; strobes are masked by reset so nothing escapes a reset cycle.
    always_comb begin
        req_ready = (state == S_IDLE);
        rf_we     = ((state == S_WB) || (state == S_WB2)) && !reset;
        rf_waddr  = (state == S_WB2) ? (rd_q + REG_AW'(1)) : rd_q;
        rf_wdata  = (state == S_WB2) ? d_q : c_q;
        done      = (((state == S_EXEC) && (!op_legal || op_cmp)) ||
                     ((state == S_WB) && !op_mul) ||
                     (state == S_WB2)) && !reset;
        illegal   = (state == S_EXEC) && !op_legal && !reset;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            c_q        <= '0;
            d_q        <= '0;
            flag_low   <= 1'b0;
            flag_neg   <= 1'b0;
            flag_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        rd_q <= req_rd;
                        rs_q <= req_rs;
                    end
                end
                S_READ: begin
                    alu_opcode <= op_q;
                    if (op_shift) begin
                        alu_a <= rf_rdata_b;
                        alu_b <= rf_rdata_a;
                    end else begin
                        alu_a <= rf_rdata_a;
                        alu_b <= rf_rdata_b;
                    end
                end
                S_EXEC: begin
                    c_q <= alu_c;
                    d_q <= alu_d;
                    if (op_legal) begin
                        flag_low  <= alu_low;
                        flag_neg  <= alu_negative;
                        flag_zero <= alu_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [3:0]  req_rd, req_rs;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [15:0] rf_rdata_a, rf_rdata_b;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_c, alu_d;
    logic        alu_low, alu_negative, alu_zero;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        flag_low, flag_neg, flag_zero;
    logic        done, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_seq #(.DATA_W(16), .REG_AW(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_c(alu_c), .alu_d(alu_d),
        .alu_low(alu_low), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_low(flag_low), .flag_neg(flag_neg), .flag_zero(flag_zero),
        .done(done), .illegal(illegal)
    );

    // Bench ALU: returns {c, d, low, neg, zero}
    function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [15:0] c, d;
        c = '0;
        p = 32'(a) * 32'(b);
        case (op)
            4'h0: c = a + b;
            4'h1: c = a - b;
            4'h2: c = a - b;
            4'h3: c = b - a;
            4'h4: c = a & b;
            4'h5: c = a | b;
            4'h6: c = a ^ b;
            4'h7: c = ~a;
            4'h8: c = b << a[3:0];
            4'h9: c = b >> a[3:0];
            4'hA: c = $signed(b) >>> a[3:0];
            4'hB: c = p[31:16];
            4'hC: c = p[23:8];
            default: c = '0;
        endcase
        d = (op == 4'hB) ? p[15:0] : c;
        return {c, d, (a < b), d[15], (c == 16'h0)};
    endfunction

    logic [34:0] alu_res;
    always_comb alu_res = alu_f(alu_opcode, alu_a, alu_b);
    assign alu_c        = alu_res[34:19];
    assign alu_d        = alu_res[18:3];
    assign alu_low      = alu_res[2];
    assign alu_negative = alu_res[1];
    assign alu_zero     = alu_res[0];

    // Register file with a bench-side preload port
    logic [15:0] regs [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    assign rf_rdata_a = regs[rf_raddr_a];
    assign rf_rdata_b = regs[rf_raddr_b];
    always @(posedge clk) begin
        if (pre_we)     regs[pre_addr] <= pre_data;
        else if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: each accepted instruction expands into a list
    // of expected per-cycle observations.
    typedef struct {
        bit          ready;
        bit          we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        bit          done;
        bit          ill;
        bit          chk_alu;
        logic [15:0] ea, eb;
        logic [3:0]  eop;
        bit          upd;
        logic [2:0]  fl;
    } rec_t;

    rec_t q[$];
    bit   m_ready_now = 1'b0;
    logic [2:0] m_flags = 3'b000;
    int   n_acc = 0;

    always @(posedge clk) begin
        if (!reset && req_valid && m_ready_now) begin
            bit sh, legal, cmp, mul;
            logic [15:0] a, b;
            logic [34:0] r;
            rec_t rec;
            sh    = (req_op == 4'h8) || (req_op == 4'h9) || (req_op == 4'hA);
            legal = (req_op <= 4'hC);
            cmp   = (req_op == 4'h2) || (req_op == 4'h3);
            mul   = (req_op == 4'hB);
            a = sh ? regs[req_rs] : regs[req_rd];
            b = sh ? regs[req_rd] : regs[req_rs];
            r = alu_f(req_op, a, b);
            rec = '{default: 0};
            q.push_back(rec);
            rec.chk_alu = 1; rec.ea = a; rec.eb = b; rec.eop = req_op;
            rec.done = !legal || cmp; rec.ill = !legal;
            rec.upd = legal; rec.fl = r[2:0];
            q.push_back(rec);
            if (legal && !cmp) begin
                rec = '{default: 0};
                rec.we = 1; rec.waddr = req_rd; rec.wdata = r[34:19]; rec.done = !mul;
                q.push_back(rec);
                if (mul) begin
                    rec.waddr = req_rd + 4'd1; rec.wdata = r[18:3]; rec.done = 1;
                    q.push_back(rec);
                end
            end
            n_acc++;
        end
    end

    always @(negedge clk) begin
        rec_t rec;
        if (reset) begin
            chk("rst_we", rf_we, 0);
            chk("rst_done", done, 0);
            chk("rst_illegal", illegal, 0);
            q.delete();
            m_flags = 3'b000;
            m_ready_now = 1'b0;
        end else begin
            if (q.size() > 0) rec = q.pop_front();
            else begin rec = '{default: 0}; rec.ready = 1; end
            chk("ready", req_ready, rec.ready);
            chk("rf_we", rf_we, rec.we);
            if (rec.we) begin
                chk("rf_waddr", rf_waddr, rec.waddr);
                chk("rf_wdata", rf_wdata, rec.wdata);
            end
            chk("done", done, rec.done);
            chk("illegal", illegal, rec.ill);
            chk("flags", {flag_low, flag_neg, flag_zero}, m_flags);
            if (rec.chk_alu) begin
                chk("alu_a", alu_a, rec.ea);
                chk("alu_b", alu_b, rec.eb);
                chk("alu_opcode", alu_opcode, rec.eop);
            end
            if (rec.upd) m_flags = rec.fl;
            m_ready_now = rec.ready;
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic preset(input logic [3:0] adr, input logic [15:0] val);
        pre_we = 1'b1; pre_addr = adr; pre_data = val;
        step();
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs);
        int n, k;
        n = n_acc; k = 0;
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs;
        while (n_acc == n && k < 30) begin step(); k++; end
        req_valid = 1'b0;
        if (n_acc == n) begin
            total++; bad++;
            $display("FAIL issue_timeout: op %0h not accepted within 30 cycles", op);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q.size() != 0 || !m_ready_now) && k < 30) begin step(); k++; end
        if (k >= 30) begin
            total++; bad++;
            $display("FAIL idle_timeout: still busy after 30 cycles");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_alu_op", alu_opcode, 0);
        chk("reset_flags", {flag_low, flag_neg, flag_zero}, 0);
        chk("reset_ready", req_ready, 1);

        // ADD R1=5 + R2=7
        preset(4'd1, 16'd5); preset(4'd2, 16'd7);
        issue(4'h0, 4'd1, 4'd2); wait_idle();
        chk("add_r1", regs[1], 16'd12);
        chk("add_zero", flag_zero, 0);

        // SUB equal operands, then CMP of a register with itself
        preset(4'd3, 16'h00A0); preset(4'd4, 16'h00A0);
        issue(4'h1, 4'd3, 4'd4); wait_idle();
        chk("sub_r3", regs[3], 16'h0000);
        chk("sub_zero", flag_zero, 1);
        issue(4'h2, 4'd4, 4'd4); wait_idle();
        chk("cmp_r4_kept", regs[4], 16'h00A0);
        chk("cmp_zero", flag_zero, 1);

        // MUL with Rdest=15: high half to R15, low half wraps to R0
        preset(4'd15, 16'h1234); preset(4'd6, 16'h0100);
        issue(4'hB, 4'd15, 4'd6); wait_idle();
        chk("mul_r15", regs[15], 16'h0012);
        chk("mul_r0", regs[0], 16'h3400);

        // LSH: amount from Rsrc
        preset(4'd7, 16'h0001); preset(4'd8, 16'd4);
        issue(4'h8, 4'd7, 4'd8); wait_idle();
        chk("lsh_r7", regs[7], 16'h0010);

        // Set all flags, then an illegal opcode must leave them alone
        preset(4'd9, 16'h0001); preset(4'd10, 16'h8000);
        issue(4'hB, 4'd9, 4'd10); wait_idle();
        chk("flags_all_set", {flag_low, flag_neg, flag_zero}, 3'b111);
        issue(4'hF, 4'd1, 4'd2); wait_idle();
        chk("illegal_flags_kept", {flag_low, flag_neg, flag_zero}, 3'b111);
        chk("illegal_r1_kept", regs[1], 16'd12);

        // Reset during WB of an ADD: R9=0 + R10=0x8000 sets low/neg in EXEC
        issue(4'h0, 4'd9, 4'd10);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("wbrst_ready", req_ready, 1);
        chk("wbrst_flags", {flag_low, flag_neg, flag_zero}, 3'b000);
        wait_idle();
        chk("wbrst_r9_kept", regs[9], 16'h0000);

        // Randomised traffic
        for (int it = 0; it < 120; it++) begin
            if (it % 20 == 0)
                for (int r = 0; r < 16; r++) preset(4'(r), 16'($urandom));
            repeat ($urandom_range(0, 2)) step();
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 3)) step();
                pulse_reset();
            end
            wait_idle();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
